seg_scan_controller: RTL and testbench
======================================

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 SHALL have parameter FREQUENCY_IN, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_FREQUENCY, default 1000, digit-slot rate in Hz; SLOT = FREQUENCY_IN/SCAN_FREQUENCY cycles, integer, >= DEAD_CYCLES+2.
REQ-003 SHALL have parameter DEAD_CYCLES, default 8, anti-ghosting blank cycles at the start of each slot.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port load_in, input, 1, request to load a new display value.
REQ-007 SHALL have port value_in, input, 16, four hex nibbles; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-008 SHALL have port dp_in, input, 4, decimal point per digit, sampled with value_in.
REQ-009 SHALL have port blank_lz_in, input, 1, leading-zero blanking enable, sampled with value_in.
REQ-010 SHALL have port bright_in, input, 3, brightness level 0..7, sampled at each slot start.
REQ-011 SHALL have port ready_out, output, 1, high when load_in will be accepted.
REQ-012 SHALL have port frame_out, output, 1, one-cycle pulse at the start of each digit-0 slot.
REQ-013 SHALL have port seg_cs_out, output, 4, one-hot active-high digit select, or all zero.
REQ-014 SHALL have port seg_data_out, output, 8, active-high segments {dp,g,f,e,d,c,b,a}.

Function
REQ-015 SHALL scan digits 0,1,2,3, then wrap to 0; each digit occupies exactly SLOT cycles.
REQ-016 SHALL use a per-slot FSM: DEAD (DEAD_CYCLES cycles, seg_cs_out=0, seg_data_out=0), then ON (ON_CYCLES cycles, seg_cs_out bit = current digit, seg_data_out = encoded digit), then OFF (remaining cycles, outputs as DEAD); OFF is skipped when it has zero length.
REQ-017 SHALL compute ON_CYCLES = max(1, ((SLOT-DEAD_CYCLES)*(bright_in+1))>>3) from bright_in sampled on the first DEAD cycle of the slot; a change of bright_in mid-slot SHALL NOT alter the current slot.
REQ-018 SHALL encode hex: 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F A=0x77 b=0x7C C=0x39 d=0x5E E=0x79 F=0x71; bit 7 = dp of that digit.
REQ-019 SHALL, with blank_lz set, blank digit n (n=3..1) segments a-g when nibble n and all higher nibbles are zero; digit 0 is never blanked; dp is unaffected by blanking.
REQ-020 SHALL accept load_in only when ready_out=1: latch value_in, dp_in, blank_lz_in into a shadow register and drop ready_out on the next cycle.
REQ-021 SHALL copy the shadow into the active register on the first cycle of the next digit-0 slot (same cycle frame_out=1), then raise ready_out on the following cycle; display therefore never tears within a frame.
REQ-022 SHALL ignore load_in while ready_out=0; a load accepted in the same cycle as a frame_out pulse SHALL be applied at the following frame, not the current one.
REQ-023 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-024 SHALL drive at most one seg_cs_out bit high in any cycle.

Reset
REQ-025 SHALL on rst low force, asynchronously: seg_cs_out=0, seg_data_out=0, frame_out=0, ready_out=1, active and shadow registers all zero, pending flag clear, digit=0, FSM=DEAD, slot counter 0.
REQ-026 SHALL start a digit-0 slot (frame_out=1) on the first clock edge after rst rises; a pending load interrupted by reset is discarded.

Verification (FREQUENCY_IN=800, SCAN_FREQUENCY=100, DEAD_CYCLES=1 -> SLOT=8)
REQ-027 SHALL check: release reset, bright_in=7, no load -> per slot 1 cycle all-off then 7 cycles cs=0001,0010,0100,1000 in turn; digit-0 data 0x3F, others 0x3F; frame_out every 32 cycles.
REQ-028 SHALL check: load value_in=0x12AF, dp_in=4'b0100, blank_lz=0 -> ready_out low until next frame_out, then digits 0..3 show 0x71, 0x77, 0xDB, 0x06.
REQ-029 SHALL check: load 0x0005, blank_lz=1 -> digit0 0x6D, digits 1-3 0x00 while cs still cycles.
REQ-030 SHALL check: bright_in=0 -> ON 1 cycle, OFF 6 cycles per slot; bright_in=3 -> ON 3, OFF 4; change mid-slot takes effect next slot.
REQ-031 SHALL check: second load_in while ready_out=0 with 0xFFFF -> ignored, display keeps first value; load in frame_out cycle -> applied one frame later.
REQ-032 SHALL check: assert rst mid-ON slot -> all outputs zero immediately, ready_out=1, display returns to all-zero value after release.

Source files
------------

// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with dead-time blanking,
// brightness duty control and frame-synchronous double-buffered updates.
module seg_scan_controller #(
    parameter int FREQUENCY_IN   = 50_000_000,
    parameter int SCAN_FREQUENCY = 1000,
    parameter int DEAD_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_in,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz_in,
    input  logic [2:0]  bright_in,
    output logic        ready_out,
    output logic        frame_out,
    output logic [3:0]  seg_cs_out,
    output logic [7:0]  seg_data_out
);

    localparam int SLOT = FREQUENCY_IN / SCAN_FREQUENCY;
    localparam int CW   = $clog2(SLOT + 1);
    localparam int PW   = CW + 4;

    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] DEAD_N    = CW'(DEAD_CYCLES);
    localparam logic [PW-1:0] ON_BASE   = PW'(SLOT - DEAD_CYCLES);

    typedef enum logic [1:0] {
        PH_DEAD,
        PH_ON,
        PH_OFF
    } phase_t;

    phase_t        phase;
    logic [CW-1:0] pos;
    logic [1:0]    digit;
    logic [CW-1:0] on_len;

    logic [15:0]   act_val;
    logic [3:0]    act_dp;
    logic          act_blz;
    logic [15:0]   sh_val;
    logic [3:0]    sh_dp;
    logic          sh_blz;
    logic          pending;
    logic          rdy_arm;

    logic [PW-1:0] on_prod;
    logic [CW-1:0] on_calc;
    logic [CW-1:0] pos_inc;
    logic          slot_start;
    logic          frame_start;
    logic          last;
    logic          on_done;
    logic          take;
    logic          apply;

    logic [3:0]    nib;
    logic          lead;
    logic [6:0]    glyph;
    logic [7:0]    seg_nxt;

    always_comb begin
        on_prod     = (ON_BASE * PW'(bright_in) + ON_BASE) >> 3;
        on_calc     = (on_prod == '0) ? CW'(1) : on_prod[CW-1:0];
        pos_inc     = pos + CW'(1);
        slot_start  = (pos == '0);
        frame_start = slot_start && (digit == 2'd0);
        last        = (pos == SLOT_LAST);
        on_done     = ((pos_inc - DEAD_N) == on_len);
        take        = load_in && ready_out;
        apply       = frame_start && pending;
    end

    // Leading-zero test looks at this nibble and everything above it.
    always_comb begin
        nib = act_val[{digit, 2'b00} +: 4];
        unique case (digit)
            2'd0:    lead = 1'b0;
            2'd1:    lead = (act_val[15:4] == '0);
            2'd2:    lead = (act_val[15:8] == '0);
            default: lead = (act_val[15:12] == '0);
        endcase
        unique case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        seg_nxt = {act_dp[digit], (act_blz && lead) ? 7'h00 : glyph};
    end

    // State holds the slot position about to be presented on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase        <= PH_DEAD;
            pos          <= '0;
            digit        <= 2'd0;
            on_len       <= CW'(1);
            act_val      <= '0;
            act_dp       <= '0;
            act_blz      <= 1'b0;
            sh_val       <= '0;
            sh_dp        <= '0;
            sh_blz       <= 1'b0;
            pending      <= 1'b0;
            rdy_arm      <= 1'b0;
            ready_out    <= 1'b1;
            frame_out    <= 1'b0;
            seg_cs_out   <= '0;
            seg_data_out <= '0;
        end else begin
            frame_out    <= frame_start;
            seg_cs_out   <= (phase == PH_ON) ? (4'b0001 << digit) : 4'b0000;
            seg_data_out <= (phase == PH_ON) ? seg_nxt : 8'h00;

            unique case (phase)
                PH_DEAD: if (pos_inc == DEAD_N) phase <= PH_ON;
                PH_ON:   if (on_done) phase <= last ? PH_DEAD : PH_OFF;
                PH_OFF:  if (last) phase <= PH_DEAD;
                default: phase <= PH_DEAD;
            endcase

            if (slot_start) on_len <= on_calc;

            if (last) begin
                pos   <= '0;
                digit <= digit + 2'd1;
            end else begin
                pos <= pos_inc;
            end

            if (apply) begin
                act_val <= sh_val;
                act_dp  <= sh_dp;
                act_blz <= sh_blz;
                pending <= 1'b0;
            end
            rdy_arm <= apply;

            if (take) begin
                sh_val    <= value_in;
                sh_dp     <= dp_in;
                sh_blz    <= blank_lz_in;
                pending   <= 1'b1;
                ready_out <= 1'b0;
            end else if (rdy_arm) begin
                ready_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized bench for seg_scan_controller against a time-indexed model
// (slot = edge/8, digit = slot%4) with SLOT=8, DEAD_CYCLES=1.
module tb_seg_scan_controller;

    localparam int SLOT = 800 / 100;
    localparam int DEAD = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_in = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz_in = 1'b0;
    logic [2:0]  bright_in = 3'd7;
    logic        ready_out;
    logic        frame_out;
    logic [3:0]  seg_cs_out;
    logic [7:0]  seg_data_out;

    int total = 0;
    int bad = 0;

    int          e;
    int          m_on;
    int          m_ready_at;
    bit          m_ready;
    bit          m_pend;
    logic [15:0] m_sh_v, m_act_v;
    logic [3:0]  m_sh_dp, m_act_dp;
    bit          m_sh_b, m_act_b;

    bit          x_frame, x_ready;
    logic [3:0]  x_cs;
    logic [7:0]  x_data;

    int glyph[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                      'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    seg_scan_controller #(
        .FREQUENCY_IN(800),
        .SCAN_FREQUENCY(100),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_in(load_in),
        .value_in(value_in),
        .dp_in(dp_in),
        .blank_lz_in(blank_lz_in),
        .bright_in(bright_in),
        .ready_out(ready_out),
        .frame_out(frame_out),
        .seg_cs_out(seg_cs_out),
        .seg_data_out(seg_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic model_reset();
        e = 0;
        m_on = 1;
        m_ready_at = -1;
        m_ready = 1'b1;
        m_pend = 1'b0;
        m_sh_v = '0;
        m_sh_dp = '0;
        m_sh_b = 1'b0;
        m_act_v = '0;
        m_act_dp = '0;
        m_act_b = 1'b0;
    endtask

    // Predicts outputs after the coming edge from the inputs now driven.
    task automatic model_edge();
        int pos, dig, n;
        bit old_rdy, lit;
        pos = e % SLOT;
        dig = (e / SLOT) % 4;
        old_rdy = m_ready;
        if (pos == 0) begin
            m_on = ((SLOT - DEAD) * (int'(bright_in) + 1)) / 8;
            if (m_on < 1) m_on = 1;
            if (dig == 0 && m_pend) begin
                m_act_v = m_sh_v;
                m_act_dp = m_sh_dp;
                m_act_b = m_sh_b;
                m_pend = 1'b0;
                m_ready_at = e + 1;
            end
        end
        if (e == m_ready_at) m_ready = 1'b1;
        if (load_in && old_rdy) begin
            m_sh_v = value_in;
            m_sh_dp = dp_in;
            m_sh_b = blank_lz_in;
            m_pend = 1'b1;
            m_ready = 1'b0;
        end
        lit = (pos >= DEAD) && (pos - DEAD < m_on);
        x_frame = (pos == 0) && (dig == 0);
        x_ready = m_ready;
        x_cs = lit ? 4'(1 << dig) : 4'h0;
        x_data = 8'h00;
        if (lit) begin
            n = int'(m_act_v >> (4 * dig));
            if (m_act_b && dig > 0 && n == 0) x_data[6:0] = 7'h00;
            else x_data[6:0] = 7'(glyph[n & 15]);
            x_data[7] = m_act_dp[dig];
        end
        e++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("frame", frame_out, x_frame);
        chk("ready", ready_out, x_ready);
        chk("cs", seg_cs_out, x_cs);
        chk("data", seg_data_out, x_data);
        chk("cs_onehot", ($countones(seg_cs_out) <= 1), 1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic b);
        value_in = v;
        dp_in = d;
        blank_lz_in = b;
        load_in = 1'b1;
        step();
        load_in = 1'b0;
    endtask

    initial begin
        int g;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", seg_cs_out, 0);
        chk("rst_data", seg_data_out, 0);
        chk("rst_frame", frame_out, 0);
        chk("rst_ready", ready_out, 1);
        @(negedge clk);
        rst = 1'b1;

        bright_in = 3'd7;
        repeat (64) step();

        repeat (3) step();
        do_load(16'h12AF, 4'b0100, 1'b0);
        repeat (5) step();
        do_load(16'hFFFF, 4'hF, 1'b1);
        repeat (70) step();

        do_load(16'h0005, 4'h0, 1'b1);
        repeat (70) step();

        bright_in = 3'd0;
        repeat (40) step();
        bright_in = 3'd3;
        repeat (36) step();
        for (g = 0; g < 20 && (e % SLOT) != 4; g++) step();
        bright_in = 3'd6;
        repeat (12) step();
        for (g = 0; g < 20 && (e % SLOT) != 3; g++) step();
        bright_in = 3'd1;
        repeat (20) step();

        for (g = 0; g < 200 && !(x_frame && x_ready); g++) step();
        chk("sync_frame", (x_frame && x_ready), 1);
        do_load(16'hBEEF, 4'b1010, 1'b0);
        repeat (80) step();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) bright_in = 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                value_in = 16'($urandom) >> ($urandom_range(0, 4) * 4);
                dp_in = 4'($urandom);
                blank_lz_in = 1'($urandom);
                load_in = 1'b1;
            end
            step();
            load_in = 1'b0;
        end

        for (g = 0; g < 200 && !(m_ready && ((e / SLOT) % 4) == 1); g++) step();
        chk("sync_load", (m_ready && ((e / SLOT) % 4) == 1), 1);
        do_load(16'h9C3D, 4'hF, 1'b0);
        for (g = 0; g < 20 && x_cs == 4'h0; g++) step();
        chk("sync_on", (x_cs != 4'h0), 1);
        rst = 1'b0;
        #1;
        chk("arst_cs", seg_cs_out, 0);
        chk("arst_data", seg_data_out, 0);
        chk("arst_frame", frame_out, 0);
        chk("arst_ready", ready_out, 1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bright_in = 3'd7;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
